redundant_core_selector: RTL and testbench
==========================================

Name: redundant_core_selector

Overview:
- Parametrised N-way successor to the dual CPU A/B switch logic.
- Watches N per-core health flags (from pulse_detection) and keeps a saturating-normalised error count per core.
- Selects one active (host) core by health, then fewest errors, and holds each selection for a minimum dwell time.
- Accepts forced-select and clear commands from the command decoder; output drives the serial-routing mux and the LEDs.

Parameters:
- N_CORES, 2, number of redundant cores (2..8).
- SEL_W, 1, index width; 2**SEL_W >= N_CORES is required.
- CNT_W, 8, width of each error counter.
- HOLDOFF, 1024, minimum cycles between voluntary switches (>=1).
- SYNC_STAGES, 2, synchroniser depth on healthy inputs (>=2).

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  reset, asynchronous, active-low.
- healthy  in  N_CORES  per-core health flag, 1 = healthy; asynchronous to clk.
- force_valid  in  1  one-cycle forced-select request.
- force_idx  in  SEL_W  target core of the forced select.
- clr_counts  in  1  one-cycle request to zero all error counters.
- sel_idx  out  SEL_W  active core index.
- sel_onehot  out  N_CORES  one-hot of sel_idx.
- switch_pulse  out  1  high for one cycle when sel_idx changes.
- force_err  out  1  high for one cycle when a force is rejected.
- all_fail  out  1  no core is healthy.
- err_cnt_flat  out  N_CORES*CNT_W  error counters; core i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset values (async): sel_idx=0, sel_onehot=1, switch_pulse=0, force_err=0, all_fail=0, all counters 0, state RUN, holdoff timer 0.
- Synchroniser flops reset to 1 (healthy).
- hs[i] = synchronised healthy[i]; err[i] = ~hs[i].
- err_rise[i] = err[i] & ~err_d[i], where err_d is a one-cycle delay of err (reset 0).
- Counter update, in priority order:
  1. clr_counts or an accepted force sets all counters to 0.
  2. Otherwise, if any counter equals 2**CNT_W-1, every counter becomes (cnt>>1) + err_rise[i].
  3. Otherwise cnt += err_rise[i].
  - Counters never wrap.
- Candidate: the healthy core with the minimum count; ties go to the lowest index.
- Automatic evaluation, by state:
  - RUN: switch when hs[sel]==0 or cnt[cand] < cnt[sel] (strictly less). Equal counts never switch.
  - HOLD: the timer decrements each cycle and the state moves to RUN when it reaches 0. Only hs[sel]==0 forces a switch in HOLD (fail-over ignores dwell).
  - FAIL: entered when no hs bit is set. sel_idx is held and all_fail=1. When any core becomes healthy, switch to the candidate and clear all_fail.
- Any switch:
  - sel_idx and sel_onehot are registered with the new value on the next edge.
  - switch_pulse=1 for exactly that cycle.
  - The timer loads HOLDOFF-1 and the state becomes HOLD.
- Force handling:
  - Accepted when force_idx < N_CORES and hs[force_idx]==1.
  - Takes priority over automatic evaluation in every state, same cycle.
  - Acts regardless of HOLD.
  - An accepted force clears the counters, reloads the timer and enters HOLD.
  - switch_pulse is asserted only if the index actually changes.
  - A rejected force gives force_err=1 for one cycle and no other effect.
- Latency:
  - A healthy edge at cycle k appears on hs at k+SYNC_STAGES.
  - The resulting sel_idx change and counter increment are visible at k+SYNC_STAGES+1.
- Simultaneous events:
  - Several cores failing in one cycle increment all their counters.
  - clr_counts in the same cycle as an err_rise clears; the increment is lost.
- Reset asserted mid-HOLD or mid-FAIL returns immediately to the reset values listed above.

Test Plan:
- N_CORES=2, HOLDOFF=16: after reset, drop healthy[0] at cycle 10 -> sel_idx=1 at cycle 13, switch_pulse for one cycle, err_cnt[0]=1.
- N_CORES=4, HOLDOFF=16:
  - Pulse err on core 0 three times, core 1 once, while sel=0 -> switch to core 2 (count 0, lowest index) only after the dwell from the previous switch expires.
  - Toggle core 2 errors within 16 cycles of that switch -> no voluntary switch until the timer reaches 0; a hard fail of core 2 switches at once.
- CNT_W=4: drive core 1 to 15 while core 0 holds 6; one more core 0 rise in the saturation cycle -> counters become 7 and 4 (core 0: 3+1; core 1: 15>>1 = 7). No wrap occurs.
- Force cases:
  - force_idx=3 with core 3 healthy -> sel_idx=3, all counters 0, HOLD entered.
  - force_idx=5 (N=4), or force_idx=1 with core 1 unhealthy -> force_err pulse, sel unchanged.
- All cores unhealthy -> all_fail=1, sel held. Restore core 2 only -> sel_idx=2, all_fail=0, switch_pulse.
- Reset pulse during HOLD with sel=3 -> sel_idx=0, counters 0, no switch_pulse.

Source files
------------

// File: rtl/redundant_core_selector.sv
// redundant_core_selector: picks one host core out of N by health and error
// history, with a dwell hold-off between voluntary switches and forced select.
module redundant_core_selector #(
   parameter int N_CORES     = 2,
   parameter int SEL_W       = 1,
   parameter int CNT_W       = 8,
   parameter int HOLDOFF     = 1024,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_CORES-1:0]       healthy,
   input  logic                     force_valid,
   input  logic [SEL_W-1:0]         force_idx,
   input  logic                     clr_counts,
   output logic [SEL_W-1:0]         sel_idx,
   output logic [N_CORES-1:0]       sel_onehot,
   output logic                     switch_pulse,
   output logic                     force_err,
   output logic                     all_fail,
   output logic [N_CORES*CNT_W-1:0] err_cnt_flat
);

   localparam int TMR_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLDOFF - 1);
   localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [N_CORES-1:0] ONE_HOT0 = N_CORES'(1);

   typedef enum logic [1:0] {RUN, HOLD, FAIL} state_t;

   state_t state, state_nx;

   logic [SYNC_STAGES-1:0][N_CORES-1:0] sync_q;
   logic [N_CORES-1:0] hs, err, err_d, err_rise;
   logic [CNT_W-1:0] cnt [N_CORES];
   logic [TMR_W-1:0] timer, timer_nx;
   logic [SEL_W-1:0] sel_nx, cand;
   logic [CNT_W-1:0] best, sel_cnt;
   logic found, sel_hs, fhs, any_hs, any_sat;
   logic force_ok, do_clear, fail_nx, ferr_nx, pulse_nx, go;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         err_d  <= '0;
      end else begin
         sync_q[0] <= healthy;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         err_d <= err;
      end
   end

   assign hs       = sync_q[SYNC_STAGES-1];
   assign err      = ~hs;
   assign err_rise = err & ~err_d;
   assign any_hs   = |hs;

   // Strict '<' keeps the lowest index on equal counts.
   always_comb begin
      cand    = '0;
      best    = CNT_MAX;
      found   = 1'b0;
      sel_hs  = 1'b0;
      sel_cnt = '0;
      fhs     = 1'b0;
      any_sat = 1'b0;
      for (int i = 0; i < N_CORES; i++) begin
         if (hs[i] && (!found || cnt[i] < best)) begin
            found = 1'b1;
            best  = cnt[i];
            cand  = SEL_W'(i);
         end
         if (sel_idx == SEL_W'(i)) begin
            sel_hs  = hs[i];
            sel_cnt = cnt[i];
         end
         if (force_idx == SEL_W'(i)) begin
            fhs = hs[i];
         end
         if (cnt[i] == CNT_MAX) begin
            any_sat = 1'b1;
         end
      end
   end

   assign force_ok = force_valid & fhs;

   always_comb begin
      state_nx = state;
      sel_nx   = sel_idx;
      timer_nx = timer;
      fail_nx  = all_fail;
      ferr_nx  = force_valid & ~force_ok;
      do_clear = clr_counts | force_ok;
      go       = 1'b0;
      if (force_ok) begin
         sel_nx   = force_idx;
         timer_nx = TMR_LOAD;
         state_nx = HOLD;
         fail_nx  = 1'b0;
      end else if (!any_hs) begin
         state_nx = FAIL;
         fail_nx  = 1'b1;
      end else begin
         unique case (state)
            RUN:  go = !sel_hs || (best < sel_cnt);
            HOLD: begin
               if (!sel_hs) begin
                  go = 1'b1;
               end else if (timer == '0) begin
                  state_nx = RUN;
               end else begin
                  timer_nx = timer - TMR_ONE;
               end
            end
            FAIL: go = 1'b1;
            default: go = 1'b0;
         endcase
         if (go) begin
            sel_nx   = cand;
            timer_nx = TMR_LOAD;
            state_nx = HOLD;
            fail_nx  = 1'b0;
         end
      end
   end

   assign pulse_nx = (sel_nx != sel_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         sel_idx      <= '0;
         timer        <= '0;
         switch_pulse <= 1'b0;
         force_err    <= 1'b0;
         all_fail     <= 1'b0;
      end else begin
         state        <= state_nx;
         sel_idx      <= sel_nx;
         timer        <= timer_nx;
         switch_pulse <= pulse_nx;
         force_err    <= ferr_nx;
         all_fail     <= fail_nx;
      end
   end

   // Halving all counters on saturation keeps their ordering without wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CORES; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CORES; i++) begin
            if (do_clear) begin
               cnt[i] <= '0;
            end else if (any_sat) begin
               cnt[i] <= (cnt[i] >> 1) + CNT_W'(err_rise[i]);
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(err_rise[i]);
            end
         end
      end
   end

   assign sel_onehot = ONE_HOT0 << sel_idx;

   for (genvar g = 0; g < N_CORES; g++) begin : g_flat
      assign err_cnt_flat[g*CNT_W +: CNT_W] = cnt[g];
   end

endmodule

// File: tb/tb_redundant_core_selector.sv
// Bench for redundant_core_selector: 4 cores, 4-bit counters, 16-cycle dwell.
module tb_redundant_core_selector;

   localparam int N  = 4;
   localparam int SW = 3;
   localparam int CW = 4;
   localparam int HO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  healthy = '1;
   logic          force_valid = 1'b0;
   logic [SW-1:0] force_idx = '0;
   logic          clr_counts = 1'b0;
   logic [SW-1:0] sel_idx;
   logic [N-1:0]  sel_onehot;
   logic          switch_pulse;
   logic          force_err;
   logic          all_fail;
   logic [N*CW-1:0] err_cnt_flat;

   redundant_core_selector #(
      .N_CORES(N), .SEL_W(SW), .CNT_W(CW),
      .HOLDOFF(HO), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .healthy(healthy),
      .force_valid(force_valid), .force_idx(force_idx),
      .clr_counts(clr_counts), .sel_idx(sel_idx),
      .sel_onehot(sel_onehot), .switch_pulse(switch_pulse),
      .force_err(force_err), .all_fail(all_fail),
      .err_cnt_flat(err_cnt_flat)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int pulses = 0;
   int ferrs = 0;

   always @(negedge clk) begin
      if (switch_pulse) pulses++;
      if (force_err) ferrs++;
   end

   typedef struct {
      logic [3:0] h;
      logic [3:0] p;
      logic       fv;
      logic [2:0] fi;
      logic       clr;
      int sel, af, c0, c1, c2, c3, np, nfe;
   } vec_t;

   vec_t tbl [10];
   vec_t sb [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int cnt(input int i);
      return int'(err_cnt_flat[i*CW +: CW]);
   endfunction

   function automatic vec_t mk(
      input logic [3:0] h, input logic [3:0] p, input logic fv,
      input logic [2:0] fi, input logic clr, input int sel, input int af,
      input int c0, input int c1, input int c2, input int c3,
      input int np, input int nfe);
      vec_t v;
      v.h = h; v.p = p; v.fv = fv; v.fi = fi; v.clr = clr;
      v.sel = sel; v.af = af; v.c0 = c0; v.c1 = c1; v.c2 = c2; v.c3 = c3;
      v.np = np; v.nfe = nfe;
      return v;
   endfunction

   task automatic apply(input int k, input vec_t v);
      vec_t e;
      int p0, f0;
      p0 = pulses;
      f0 = ferrs;
      sb.push_back(v);
      healthy = v.h & ~v.p;
      tick(); tick();
      healthy = v.h;
      tick(); tick(); tick();
      force_valid = v.fv;
      force_idx = v.fi;
      clr_counts = v.clr;
      tick();
      force_valid = 1'b0;
      clr_counts = 1'b0;
      repeat (54) tick();
      e = sb.pop_front();
      chk($sformatf("v%0d.sel", k), int'(sel_idx), e.sel);
      chk($sformatf("v%0d.onehot", k), int'(sel_onehot), 1 << e.sel);
      chk($sformatf("v%0d.all_fail", k), int'(all_fail), e.af);
      chk($sformatf("v%0d.cnt0", k), cnt(0), e.c0);
      chk($sformatf("v%0d.cnt1", k), cnt(1), e.c1);
      chk($sformatf("v%0d.cnt2", k), cnt(2), e.c2);
      chk($sformatf("v%0d.cnt3", k), cnt(3), e.c3);
      chk($sformatf("v%0d.pulses", k), pulses - p0, e.np);
      chk($sformatf("v%0d.force_err", k), ferrs - f0, e.nfe);
   endtask

   task automatic pulse_core(input int c);
      healthy[c] = 1'b0;
      tick(); tick();
      healthy[c] = 1'b1;
      tick(); tick(); tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, p0;
      //    h      p      fv    fi    clr   sel af c0 c1 c2 c3 np nfe
      tbl[0] = mk(4'hF, 4'h2, 1'b0, 3'd0, 1'b0, 2, 0, 1, 1, 0, 0, 1, 0);
      tbl[1] = mk(4'h0, 4'h0, 1'b0, 3'd0, 1'b0, 2, 1, 2, 2, 1, 1, 0, 0);
      tbl[2] = mk(4'h1, 4'h0, 1'b0, 3'd0, 1'b0, 0, 0, 2, 2, 1, 1, 1, 0);
      tbl[3] = mk(4'hF, 4'h0, 1'b0, 3'd0, 1'b0, 2, 0, 2, 2, 1, 1, 1, 0);
      tbl[4] = mk(4'hF, 4'h0, 1'b1, 3'd3, 1'b0, 3, 0, 0, 0, 0, 0, 1, 0);
      tbl[5] = mk(4'hF, 4'h0, 1'b1, 3'd5, 1'b0, 3, 0, 0, 0, 0, 0, 0, 1);
      tbl[6] = mk(4'hD, 4'h0, 1'b1, 3'd1, 1'b0, 3, 0, 0, 1, 0, 0, 0, 1);
      tbl[7] = mk(4'hF, 4'h0, 1'b0, 3'd0, 1'b1, 3, 0, 0, 0, 0, 0, 0, 0);
      tbl[8] = mk(4'hF, 4'h1, 1'b1, 3'd3, 1'b0, 3, 0, 0, 0, 0, 0, 0, 0);
      tbl[9] = mk(4'hF, 4'h8, 1'b0, 3'd0, 1'b0, 0, 0, 0, 0, 0, 1, 1, 0);

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst.sel", int'(sel_idx), 0);
      chk("rst.onehot", int'(sel_onehot), 1);
      chk("rst.pulse", int'(switch_pulse), 0);
      chk("rst.force_err", int'(force_err), 0);
      chk("rst.all_fail", int'(all_fail), 0);
      chk("rst.cnt", int'(err_cnt_flat), 0);

      // Fail-over latency: edge +2 on hs, +3 on sel_idx.
      tick(); tick();
      healthy[0] = 1'b0;
      tick(); tick();
      chk("lat.sel_early", int'(sel_idx), 0);
      chk("lat.pulse_early", int'(switch_pulse), 0);
      tick();
      chk("lat.sel", int'(sel_idx), 1);
      chk("lat.pulse", int'(switch_pulse), 1);
      chk("lat.onehot", int'(sel_onehot), 2);
      chk("lat.cnt0", cnt(0), 1);
      tick();
      chk("lat.pulse_once", int'(switch_pulse), 0);
      healthy = '1;
      repeat (30) tick();

      for (int k = 0; k < 10; k++) apply(k, tbl[k]);

      // clr_counts in the same cycle as an error rise wins.
      healthy[2] = 1'b0;
      tick(); tick();
      clr_counts = 1'b1;
      tick();
      clr_counts = 1'b0;
      chk("clr.cnt2", cnt(2), 0);
      chk("clr.cnt3", cnt(3), 0);
      tick();
      chk("clr.cnt2_hold", cnt(2), 0);
      healthy = '1;
      repeat (25) tick();

      // Voluntary switch waits out the dwell; hard fail in HOLD does not.
      healthy[0] = 1'b0;
      tick(); tick();
      healthy = '1;
      repeat (25) tick();
      healthy = '0;
      repeat (8) tick();
      chk("dw.all_fail", int'(all_fail), 1);
      chk("dw.cnt0", cnt(0), 2);
      chk("dw.cnt1", cnt(1), 1);
      healthy = 4'h1;
      tick(); tick(); tick();
      chk("dw.sel0", int'(sel_idx), 0);
      chk("dw.pulse0", int'(switch_pulse), 1);
      chk("dw.all_fail_clr", int'(all_fail), 0);
      healthy = '1;
      n = 0;
      for (int t = 1; t <= 40; t++) begin
         tick();
         n = t;
         if (sel_idx == 3'd1) break;
      end
      checks++;
      if (n < HO || n > HO + 3 || sel_idx != 3'd1) begin
         errors++;
         $display("FAIL dw.dwell: sel=%0d after %0d cycles, expected 1 after %0d..%0d",
                  sel_idx, n, HO, HO + 3);
      end
      tick();
      healthy[1] = 1'b0;
      tick(); tick();
      chk("hf.sel_early", int'(sel_idx), 1);
      tick();
      chk("hf.sel", int'(sel_idx), 2);
      chk("hf.pulse", int'(switch_pulse), 1);
      chk("hf.cnt1", cnt(1), 2);
      healthy = '1;
      repeat (30) tick();

      // Saturation halves every counter and adds the concurrent rise.
      clr_counts = 1'b1;
      tick();
      clr_counts = 1'b0;
      for (int r = 0; r < 6; r++) pulse_core(0);
      for (int r = 0; r < 14; r++) pulse_core(1);
      chk("sat.pre0", cnt(0), 6);
      chk("sat.pre1", cnt(1), 14);
      healthy[1] = 1'b0;
      tick();
      healthy[0] = 1'b0;
      tick(); tick();
      chk("sat.max1", cnt(1), 15);
      chk("sat.max0", cnt(0), 6);
      tick();
      chk("sat.half1", cnt(1), 7);
      chk("sat.half0", cnt(0), 4);
      chk("sat.half2", cnt(2), 0);
      tick();
      chk("sat.nowrap1", cnt(1), 7);
      chk("sat.nowrap0", cnt(0), 4);
      healthy = '1;
      repeat (30) tick();

      // Asynchronous reset in the middle of HOLD.
      force_idx = 3'd3;
      force_valid = 1'b1;
      tick();
      force_valid = 1'b0;
      chk("rh.sel3", int'(sel_idx), 3);
      chk("rh.cnt_clr", cnt(1), 0);
      pulse_core(0);
      chk("rh.cnt0", cnt(0), 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rh.sel", int'(sel_idx), 0);
      chk("rh.onehot", int'(sel_onehot), 1);
      chk("rh.pulse", int'(switch_pulse), 0);
      chk("rh.cnt", int'(err_cnt_flat), 0);
      @(negedge clk);
      rst_n = 1'b1;
      p0 = pulses;
      repeat (6) tick();
      chk("rh.sel_after", int'(sel_idx), 0);
      chk("rh.no_pulse", pulses - p0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
